// File: rtl/board_pkg.sv
// Board-level constants and shared types for the CPU ROM path.
// Holds the SDRAM placement of the ROM image and the line/word types.
package board_pkg;

    localparam logic [24:0] ROM_SDR_BASE = 25'h0300000;

    localparam int ROM_ADDR_W = 20;
    localparam int SDR_ADDR_W = 25;
    localparam int TAG_W      = 17;
    localparam int LINE_W     = 64;
    localparam int WORD_W     = 16;

    typedef logic [TAG_W-1:0]  rom_tag_t;
    typedef logic [LINE_W-1:0] rom_line_t;
    typedef logic [WORD_W-1:0] rom_word_t;

    function automatic rom_word_t line_word(input rom_line_t line, input logic [1:0] sel);
        return line[WORD_W*sel +: WORD_W];
    endfunction

endpackage

// File: rtl/rom_line_buf.sv
// Single-line ROM buffer: tag, valid and one 4-word SDRAM burst with word mux.
// Latency: fill/flush take effect next cycle; hit and word are combinational.
// Backpressure: none; flush beats a coincident fill for the valid bit.
module rom_line_buf
    import board_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fill,
    input  rom_tag_t         fill_tag,
    input  rom_line_t        fill_data,
    input  logic             flush,
    input  rom_tag_t         lookup_tag,
    input  logic [1:0]       word_sel,
    output logic             hit,
    output rom_word_t        word
);

    logic      valid_q;
    rom_tag_t  tag_q;
    rom_line_t line_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            line_q  <= '0;
        end else begin
            if (fill) begin
                tag_q   <= fill_tag;
                line_q  <= fill_data;
                valid_q <= 1'b1;
            end
            // data still lands on a flushed fill so the pending read is served
            if (flush) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign hit  = valid_q && (tag_q == lookup_tag);
    assign word = line_word(line_q, word_sel);

endmodule

// File: rtl/cpu_rom_responder.sv
// Serves CPU ROM reads from a one-line buffer, refilling 8-byte lines from SDRAM.
// Latency: hit/write ready in the 2nd cycle of memrq; miss ready the cycle after sdr_ack.
// Backpressure: CPU holds its request until ready; sdr_req is held until sdr_ack.
module cpu_rom_responder
    import board_pkg::*;
#(
    parameter logic [24:0] SDR_BASE = 25'h0000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memrq,
    input  logic        rd,
    input  logic [19:0] rom_addr,
    input  logic        flush,
    output logic [15:0] dout,
    output logic        ready,
    output logic        sdr_req,
    output logic [24:0] sdr_addr,
    input  logic        sdr_ack,
    input  logic [63:0] sdr_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t    state_q, state_d;
    logic      resp_rd_q, resp_rd_d;
    logic      abandon_q;
    logic      start_fetch;
    logic      fill;
    logic      hit;
    rom_word_t word;
    rom_word_t dout_q;
    rom_tag_t  req_tag;
    logic      unused_addr_bit;

    assign req_tag         = rom_addr[19:3];
    assign unused_addr_bit = rom_addr[0];

    rom_line_buf u_line_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .fill       (fill),
        .fill_tag   (req_tag),
        .fill_data  (sdr_data),
        .flush      (flush),
        .lookup_tag (req_tag),
        .word_sel   (rom_addr[2:1]),
        .hit        (hit),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        resp_rd_d   = resp_rd_q;
        start_fetch = 1'b0;
        fill        = 1'b0;
        ready       = 1'b0;
        case (state_q)
            IDLE: begin
                if (memrq) begin
                    if (!rd) begin
                        state_d   = RESP;
                        resp_rd_d = 1'b0;
                    end else if (hit) begin
                        state_d   = RESP;
                        resp_rd_d = 1'b1;
                    end else begin
                        state_d     = FETCH;
                        start_fetch = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (sdr_ack) begin
                    fill      = 1'b1;
                    resp_rd_d = 1'b1;
                    // a CPU that walked away still gets its line buffered, but no ready
                    state_d   = (abandon_q || !memrq) ? IDLE : RESP;
                end
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            resp_rd_q <= 1'b0;
            abandon_q <= 1'b0;
            sdr_req   <= 1'b0;
            sdr_addr  <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            resp_rd_q <= resp_rd_d;
            if (start_fetch) begin
                sdr_req   <= 1'b1;
                sdr_addr  <= SDR_BASE + 25'({rom_addr[19:3], 3'b000});
                abandon_q <= 1'b0;
            end else if (state_q == FETCH) begin
                if (sdr_ack) begin
                    sdr_req <= 1'b0;
                end
                if (!memrq) begin
                    abandon_q <= 1'b1;
                end
            end
            if (state_q == RESP && resp_rd_q) begin
                dout_q <= word;
            end
        end
    end

    // the word is live during RESP; the register keeps it visible afterwards
    assign dout = (state_q == RESP && resp_rd_q) ? word : dout_q;

endmodule

// File: tb/tb_cpu_rom_responder.sv
// Randomized bench for cpu_rom_responder against a one-line-cache reference model.
module tb_cpu_rom_responder;
    import board_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        memrq = 1'b0;
    logic        rd = 1'b0;
    logic [19:0] rom_addr = '0;
    logic        flush = 1'b0;
    logic [15:0] dout;
    logic        ready;
    logic        sdr_req;
    logic [24:0] sdr_addr;
    logic        sdr_ack = 1'b0;
    logic [63:0] sdr_data = '0;

    int total = 0;
    int bad   = 0;

    // reference model: what a single-line ROM cache must contain
    logic        m_valid = 1'b0;
    logic [16:0] m_tag   = '0;
    logic [63:0] m_line  = '0;
    logic [15:0] m_dout  = '0;

    cpu_rom_responder #(.SDR_BASE(ROM_SDR_BASE)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .memrq    (memrq),
        .rd       (rd),
        .rom_addr (rom_addr),
        .flush    (flush),
        .dout     (dout),
        .ready    (ready),
        .sdr_req  (sdr_req),
        .sdr_addr (sdr_addr),
        .sdr_ack  (sdr_ack),
        .sdr_data (sdr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rom_image(input logic [19:0] a);
        logic [15:0] t;
        t = a[18:3];
        return {t ^ 16'hA5A5, t + 16'h1111, t * 16'd3, ~t};
    endfunction

    function automatic logic [15:0] word_of(input logic [63:0] l, input logic [19:0] a);
        logic [63:0] s;
        s = l >> (16 * a[2:1]);
        return s[15:0];
    endfunction

    // one complete CPU access; memrq is raised in an IDLE cycle (counted as cycle 1)
    task automatic do_access(input logic [19:0] a, input logic is_rd, input int dly,
                             input logic fl, input logic [63:0] dat);
        logic exp_miss, saw_req, got_ready;
        int   req_c, ack_c, rdy_c;
        logic [24:0] exp_addr;
        logic [15:0] rdy_dout;
        logic        rdy_req;
        exp_miss  = is_rd && !(m_valid && m_tag == a[19:3]);
        exp_addr  = ROM_SDR_BASE + 25'(a & ~20'h7);
        saw_req   = 1'b0;
        got_ready = 1'b0;
        req_c = 0; ack_c = 0; rdy_c = 0;
        rdy_dout = '0; rdy_req = 1'b0;
        memrq = 1'b1; rd = is_rd; rom_addr = a;
        for (int c = 2; c < 60 && !got_ready; c++) begin
            @(posedge clk); #1;
            sdr_ack = 1'b0;
            flush   = 1'b0;
            if (ready) begin
                got_ready = 1'b1;
                rdy_c     = c;
                rdy_dout  = dout;
                rdy_req   = sdr_req;
            end else if (sdr_req) begin
                if (!saw_req) begin
                    saw_req = 1'b1;
                    req_c   = c;
                    chk("sdr_addr", sdr_addr, exp_addr);
                end
                if (c - req_c == dly) begin
                    sdr_ack  = 1'b1;
                    sdr_data = dat;
                    flush    = fl;
                    ack_c    = c;
                end
            end
        end
        chk("ready_seen", got_ready, 1'b1);
        chk("fetch_issued", saw_req, exp_miss);
        chk("req_low_at_ready", rdy_req, 1'b0);
        if (exp_miss) begin
            m_tag   = a[19:3];
            m_line  = dat;
            m_valid = !fl;
            chk("miss_latency", rdy_c, ack_c + 1);
        end else begin
            chk("hit_latency", rdy_c, 2);
        end
        if (is_rd) m_dout = word_of(m_line, a);
        chk("dout_at_ready", rdy_dout, m_dout);
        memrq = 1'b0;
        @(posedge clk); #1;
        chk("ready_one_cycle", ready, 1'b0);
        chk("dout_hold", dout, m_dout);
    endtask

    initial begin
        logic [19:0] a;
        logic [16:0] tags [4];
        logic        seen;
        tags[0] = 17'h00000; tags[1] = 17'h00001; tags[2] = 17'h00002; tags[3] = 17'h1FFFF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_req", sdr_req, 1'b0);
        chk("rst_addr", sdr_addr, 25'h0);
        chk("rst_dout", dout, 16'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // cold read, hit follow-up, next-line miss
        do_access(20'h00006, 1'b1, 0, 1'b0, 64'h4444_3333_2222_1111);
        chk("cold_dout", m_dout, 16'h4444);
        do_access(20'h00002, 1'b1, 0, 1'b0, 64'h0);
        chk("hit_dout", dout, 16'h2222);
        do_access(20'h00008, 1'b1, 2, 1'b0, rom_image(20'h00008));

        // flush coincident with ack, then the same line must refetch
        do_access(20'h00010, 1'b1, 1, 1'b1, rom_image(20'h00010));
        do_access(20'h00012, 1'b1, 0, 1'b0, rom_image(20'h00010));

        // ROM write: ready only, buffer and dout untouched
        do_access(20'h00014, 1'b0, 0, 1'b0, 64'h0);
        do_access(20'h00016, 1'b1, 0, 1'b0, 64'h0);

        // CPU abandons a miss: line still fills, no ready
        memrq = 1'b1; rd = 1'b1; rom_addr = 20'h00020;
        @(posedge clk); #1;
        chk("abandon_req", sdr_req, 1'b1);
        memrq = 1'b0;
        @(posedge clk); #1;
        sdr_ack = 1'b1; sdr_data = rom_image(20'h00020);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            sdr_ack = 1'b0;
            if (ready) seen = 1'b1;
        end
        chk("abandon_no_ready", seen, 1'b0);
        chk("abandon_req_drop", sdr_req, 1'b0);
        m_valid = 1'b1; m_tag = 17'h00004; m_line = rom_image(20'h00020);
        do_access(20'h00024, 1'b1, 0, 1'b0, 64'h0);

        // reset mid-fetch, then a stray ack
        memrq = 1'b1; rd = 1'b1; rom_addr = 20'h00030;
        @(posedge clk); #1;
        chk("pre_reset_req", sdr_req, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("reset_req_drop", sdr_req, 1'b0);
        memrq = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_valid = 1'b0; m_tag = '0; m_line = '0; m_dout = '0;
        sdr_ack = 1'b1; sdr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            sdr_ack = 1'b0;
            if (ready || sdr_req) seen = 1'b1;
        end
        chk("stray_ack_ignored", seen, 1'b0);
        do_access(20'h00030, 1'b1, 1, 1'b0, rom_image(20'h00030));

        // random traffic over a few lines so hits and misses both occur
        for (int i = 0; i < 40; i++) begin
            a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 5) == 0) begin
                flush = 1'b1;
                m_valid = 1'b0;
                @(posedge clk); #1;
                flush = 1'b0;
            end
            do_access(a, ($urandom_range(0, 4) != 0), $urandom_range(0, 4),
                      ($urandom_range(0, 6) == 0), rom_image(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
